// File: rtl/mat_stream_formatter_pkg.sv
// Shared definitions for the matrix result stream formatter and its FIFO.
package mat_stream_formatter_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // Positions within the per-element byte sequence
    localparam logic [2:0] POS_HUND = 3'd0;
    localparam logic [2:0] POS_TENS = 3'd1;
    localparam logic [2:0] POS_ONES = 3'd2;
    localparam logic [2:0] POS_SEP  = 3'd3;
    localparam logic [2:0] POS_LF   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_EMIT,
        S_DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Byte presented at a given sequence position for the current element
    function automatic logic [7:0] seq_byte(
        input logic [2:0] pos,
        input logic [1:0] hund,
        input logic [3:0] tens,
        input logic [3:0] ones,
        input logic       row_end
    );
        logic [7:0] b;
        case (pos)
            POS_HUND: b = CH_ZERO + 8'(hund);
            POS_TENS: b = CH_ZERO + 8'(tens);
            POS_ONES: b = CH_ZERO + 8'(ones);
            POS_SEP:  b = row_end ? CH_CR : CH_SPACE;
            default:  b = CH_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mat_stream_formatter_sync.sv
// Synchronous FIFO with extra-MSB pointers; combinational read data at the head.
module sync_fifo
    import mat_stream_formatter_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int ADDR = int'(clog2(DEPTH));

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR:0]    wr_ptr;
    logic [ADDR:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]) && (wr_ptr[ADDR] != rd_ptr[ADDR]);
    assign dout  = mem[rd_ptr[ADDR-1:0]];

    // Pointer update; clear flushes, a pop never makes room for a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (ADDR+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (ADDR+1)'(1);
            end
        end
    end

    // Storage array, not reset
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem[wr_ptr[ADDR-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mat_stream_formatter.sv
// Buffers matrix elements and emits them as ASCII decimal over a byte handshake.
module mat_stream_formatter
    import mat_stream_formatter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_elem,
    input  logic                  in_row_end,
    input  logic                  in_last,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int ENTRY_W = DATA_WIDTH + 2;

    state_t             state;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;

    logic [7:0]         rem;
    logic [1:0]         hund;
    logic [3:0]         tens;
    logic [3:0]         ones;
    logic [2:0]         idx;
    logic               cur_last;
    logic               cur_row_end;

    logic [2:0]         first_idx;
    logic [7:0]         first_byte;
    logic [7:0]         next_byte;
    logic               last_byte;

    assign fifo_push = in_valid && !fifo_full && !clear;
    assign fifo_pop  = (state == S_LOAD) && !clear;
    assign fifo_din  = {in_last, in_row_end, in_elem};
    assign busy      = !fifo_empty || (state != S_IDLE);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Byte selection: leading-zero suppression for the first byte, and the
    // successor of the byte currently on the bus
    always_comb begin
        first_idx  = (hund != 2'd0) ? POS_HUND : ((tens != 4'd0) ? POS_TENS : POS_ONES);
        first_byte = seq_byte(first_idx, hund, tens, rem[3:0], cur_row_end);
        next_byte  = seq_byte(idx + 3'd1, hund, tens, ones, cur_row_end);
        last_byte  = (idx == POS_LF) || ((idx == POS_SEP) && !cur_row_end);
    end

    // Control FSM with registered handshake outputs; the first byte is loaded
    // on the conversion exit edge so tx_valid rises in the first emit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            rem         <= '0;
            hund        <= '0;
            tens        <= '0;
            ones        <= '0;
            idx         <= '0;
            cur_last    <= 1'b0;
            cur_row_end <= 1'b0;
        end else if (clear) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_valid && fifo_full) begin
                overflow <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rem         <= 8'(fifo_dout[DATA_WIDTH-1:0]);
                    hund        <= '0;
                    tens        <= '0;
                    cur_row_end <= fifo_dout[DATA_WIDTH];
                    cur_last    <= fifo_dout[DATA_WIDTH+1];
                    state       <= S_CONV;
                end
                S_CONV: begin
                    if (rem >= 8'd100) begin
                        rem  <= rem - 8'd100;
                        hund <= hund + 2'd1;
                    end else if (rem >= 8'd10) begin
                        rem  <= rem - 8'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        ones     <= rem[3:0];
                        idx      <= first_idx;
                        tx_data  <= first_byte;
                        tx_valid <= 1'b1;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (tx_ready) begin
                        if (last_byte) begin
                            tx_valid <= 1'b0;
                            done     <= cur_last;
                            state    <= cur_last ? S_DONE : S_IDLE;
                        end else begin
                            idx     <= idx + 3'd1;
                            tx_data <= next_byte;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_stream_formatter.sv
// Self-checking bench: byte-level reference model of the ASCII stream plus directed scenarios.
module tb_mat_stream_formatter;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_elem;
    logic       in_row_end;
    logic       in_last;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       overflow;

    int         n_checks;
    int         n_fail;
    int         done_count;
    logic [8:0] exp_q[$];
    logic [7:0] got_log[$];
    logic       done_due;
    logic       hold_prev;
    logic [7:0] hold_data;
    bit         rand_ready;

    mat_stream_formatter #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_elem    (in_elem),
        .in_row_end (in_row_end),
        .in_last    (in_last),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: decimal digits without leading zeros, then separator
    task automatic model_elem(input int v, input bit re, input bit la);
        logic [8:0] e;
        if (v >= 100) exp_q.push_back({1'b0, 8'(48 + v / 100)});
        if (v >= 10)  exp_q.push_back({1'b0, 8'(48 + (v / 10) % 10)});
        exp_q.push_back({1'b0, 8'(48 + v % 10)});
        if (re) begin
            exp_q.push_back({1'b0, 8'd13});
            exp_q.push_back({1'b0, 8'd10});
        end else begin
            exp_q.push_back({1'b0, 8'd32});
        end
        if (la) begin
            e = exp_q.pop_back();
            e[8] = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input int v, input bit re, input bit la, input bit accepted);
        in_valid   = 1'b1;
        in_elem    = 8'(v);
        in_row_end = re;
        in_last    = la;
        step();
        in_valid   = 1'b0;
        in_row_end = 1'b0;
        in_last    = 1'b0;
        if (accepted) model_elem(v, re, la);
    endtask

    task automatic wait_done(input int base, input int budget);
        int n;
        n = 0;
        while (done_count == base && n < budget) begin
            step();
            n++;
        end
        chk("done_seen", 32'(done_count - base), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!tx_valid && n < budget) begin
            step();
            n++;
        end
        chk("tx_valid_seen", 32'(tx_valid), 32'd1);
    endtask

    task automatic latency_to_valid(output int lat);
        lat = 0;
        while (!tx_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic check_log(input string s);
        chk("log_len", 32'(got_log.size()), 32'(s.len()));
        for (int i = 0; i < s.len() && i < got_log.size(); i++) begin
            chk("log_byte", 32'(got_log[i]), 32'(s[i]));
        end
    endtask

    task automatic async_reset_check();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        got_log.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    endtask

    // Compare process: every byte transfer, done timing and handshake stability
    task automatic monitor_loop();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_due  = 1'b0;
                hold_prev = 1'b0;
            end else begin
                chk("done_pulse", 32'(done), 32'(done_due));
                done_due = 1'b0;
                if (done) done_count++;
                if (hold_prev) begin
                    chk("hold_valid", 32'(tx_valid), 32'd1);
                    chk("hold_data", 32'(tx_data), 32'(hold_data));
                end
                hold_prev = 1'b0;
                if (!clear && tx_valid) begin
                    if (tx_ready) begin
                        chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                            done_due = e[8];
                        end
                        got_log.push_back(tx_data);
                    end else begin
                        hold_prev = 1'b1;
                        hold_data = tx_data;
                    end
                end
            end
        end
    endtask

    task automatic run_tests();
        int base;
        int lat;
        int n;
        int seps;
        int rows;
        int cols;

        // Reset values
        step();
        step();
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();

        // 1x1, element 0
        got_log.delete();
        base = done_count;
        push(0, 1, 1, 1);
        chk("busy_after_push", 32'(busy), 32'd1);
        latency_to_valid(lat);
        chk("latency_elem0", 32'(lat), 32'd3);
        wait_done(base, 100);
        check_log("0\015\012");
        chk("overflow_1x1", 32'(overflow), 32'd0);

        // 1x1, element 255: longest conversion
        got_log.delete();
        base = done_count;
        push(255, 1, 1, 1);
        latency_to_valid(lat);
        chk("latency_elem255", 32'(lat), 32'd10);
        wait_done(base, 100);
        check_log("255\015\012");

        // 2x2 matrix at 2-cycle spacing
        got_log.delete();
        base = done_count;
        push(1, 0, 0, 1);   step();
        push(23, 1, 0, 1);  step();
        push(255, 0, 0, 1); step();
        push(100, 1, 1, 1);
        wait_done(base, 300);
        check_log("1 23\015\012255 100\015\012");

        // Same matrix with a 10-cycle stall on the leading '2' of 255
        got_log.delete();
        base = done_count;
        push(1, 0, 0, 1);   step();
        push(23, 1, 0, 1);  step();
        push(255, 0, 0, 1); step();
        push(100, 1, 1, 1);
        n = 0;
        while (got_log.size() < 6 && n < 200) begin step(); n++; end
        n = 0;
        while (!(tx_valid && tx_data == 8'h32) && n < 200) begin step(); n++; end
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_data", 32'(tx_data), 32'h32);
        tx_ready = 1'b1;
        wait_done(base, 300);
        check_log("1 23\015\012255 100\015\012");

        // Overflow: one element held on the bus, 64 fill the FIFO, one is dropped
        got_log.delete();
        base = done_count;
        tx_ready = 1'b0;
        push(9, 0, 0, 1);
        wait_valid(50);
        for (int i = 0; i < 64; i++) begin
            push(int'($urandom_range(0, 255)), i == 63, i == 63, 1);
        end
        chk("overflow_when_full", 32'(overflow), 32'd0);
        push(77, 1, 1, 0);
        chk("overflow_set", 32'(overflow), 32'd1);
        tx_ready = 1'b1;
        wait_done(base, 5000);
        seps = 0;
        foreach (got_log[i]) if (got_log[i] == 8'd32 || got_log[i] == 8'd10) seps++;
        chk("elements_formatted", 32'(seps), 32'd65);
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // Clear during emission with 5 entries still buffered
        got_log.delete();
        tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(11 * i, 0, 0, 1);
        wait_valid(50);
        clear = 1'b1;
        exp_q.delete();
        step();
        clear = 1'b0;
        chk("clear_tx_valid", 32'(tx_valid), 32'd0);
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_overflow", 32'(overflow), 32'd0);
        got_log.delete();
        tx_ready = 1'b1;
        base = done_count;
        push(7, 1, 1, 1);
        wait_done(base, 100);
        check_log("7\015\012");

        // Asynchronous reset while a byte is held on the bus
        tx_ready = 1'b0;
        push(5, 0, 0, 1);
        push(255, 0, 0, 1);
        push(200, 1, 1, 1);
        wait_valid(50);
        async_reset_check();
        tx_ready = 1'b1;

        // Asynchronous reset mid-conversion
        push(255, 0, 0, 1);
        push(42, 1, 1, 1);
        step();
        step();
        chk("busy_in_conv", 32'(busy), 32'd1);
        async_reset_check();

        // Randomized matrices with random back-pressure
        rand_ready = 1'b1;
        for (int m = 0; m < 8; m++) begin
            rows = int'($urandom_range(1, 7));
            cols = int'($urandom_range(1, 7));
            base = done_count;
            for (int r = 0; r < rows; r++) begin
                for (int c = 0; c < cols; c++) begin
                    push(int'($urandom_range(0, 255)), c == cols - 1,
                         (r == rows - 1) && (c == cols - 1), 1);
                    n = int'($urandom_range(0, 2));
                    for (int k = 0; k < n; k++) step();
                end
            end
            wait_done(base, 20000);
            step();
            chk("idle_after_matrix", 32'(busy), 32'd0);
        end
        rand_ready = 1'b0;
        tx_ready = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        done_count = 0;
        done_due   = 1'b0;
        hold_prev  = 1'b0;
        hold_data  = '0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_elem    = '0;
        in_row_end = 1'b0;
        in_last    = 1'b0;
        tx_ready   = 1'b1;
        fork
            monitor_loop();
            run_tests();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
